// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle for ahb_sram_slave: address/data phase signals plus
// the per-beat wait-state request. The master modport drives the i_* side.
interface ahb_sram_slave_if #(
  parameter int DATA_WDT = 32
);
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic [3:0]          i_wait;
  logic [DATA_WDT-1:0] o_hrdata;
  logic                o_hready;
  logic [1:0]          o_hresp;

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
    input  i_hwdata, i_hready, i_wait,
    output o_hrdata, o_hready, o_hresp
  );

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
    output i_hwdata, i_hready, i_wait,
    input  o_hrdata, o_hready, o_hresp
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB responder in front of a byte-addressed SRAM. Accepts a transfer in the
// address phase, stretches the data phase by a programmable wait count, commits
// writes with byte-lane enables and answers illegal accesses with a two-cycle
// ERROR response.
module ahb_sram_slave #(
  parameter int DATA_WDT  = 32,
  parameter int MEM_DEPTH = 256
) (
  input logic             i_hclk,
  input logic             i_hreset,
  ahb_sram_slave_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]    state_q,   state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic          write_q,   write_d;
  logic [1:0]    size_q,    size_d;

  logic [7:0]    mem [MEM_DEPTH];

  logic          readyState;
  logic          accept;
  logic          addrErr;
  logic [AW-1:0] wordBase;
  logic [3:0]    laneEn;
  logic          unusedBits;

  // Burst type and the BUSY/IDLE distinction carry no meaning here; every beat
  // brings its own address.
  assign unusedBits = ^{bus.i_hburst, bus.i_htrans[0]};

  // The slave only listens to a new address phase in states where it is itself
  // driving HREADY high, so a bus-level HREADY glitch cannot start a transfer
  // in the middle of a stretched data phase.
  assign readyState = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign accept     = bus.i_hready & bus.i_hsel & bus.i_htrans[1] & readyState;

  // Out of range, reserved size, or a halfword/word that is not naturally aligned.
  assign addrErr = (bus.i_haddr >= 32'(MEM_DEPTH))
                 || (bus.i_hsize > 3'd2)
                 || ((bus.i_hsize == 3'd1) && bus.i_haddr[0])
                 || ((bus.i_hsize == 3'd2) && (bus.i_haddr[1:0] != 2'b00));

  // Masking keeps this valid even for a 4-byte memory where AW is only 2.
  assign wordBase = addr_q & ~(AW'(3));

  // Byte lanes touched by the registered transfer, little-endian.
  always_comb begin
    laneEn = 4'b1111;
    case (size_q)
      2'd0:    laneEn = 4'b0001 << addr_q[1:0];
      2'd1:    laneEn = addr_q[1] ? 4'b1100 : 4'b0011;
      default: laneEn = 4'b1111;
    endcase
  end

  // Next-state logic: IDLE, LAST and ERR2 are all "ready" states where a fresh
  // address phase is evaluated identically.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    case (state_q)
      ST_WAIT: begin
        if (waitCnt_q <= 4'd1) begin
          state_d   = ST_LAST;
          waitCnt_d = 4'd0;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        if (accept) begin
          addr_d  = bus.i_haddr[AW-1:0];
          write_d = bus.i_hwrite;
          size_d  = bus.i_hsize[1:0];
          if (addrErr) begin
            state_d   = ST_ERR1;
            waitCnt_d = 4'd0;
          end else if (bus.i_wait != 4'd0) begin
            state_d   = ST_WAIT;
            waitCnt_d = bus.i_wait;
          end else begin
            state_d   = ST_LAST;
            waitCnt_d = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Control registers; reset returns to IDLE and clears the wait counter.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
    end
  end

  // Write commits on the edge that closes LAST; a reset on that edge drops it.
  always_ff @(posedge i_hclk) begin
    if (!i_hreset && (state_q == ST_LAST) && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) begin
          mem[wordBase | AW'(k)] <= bus.i_hwdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.o_hready = readyState;
  assign bus.o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'd1 : 2'd0;
  assign bus.o_hrdata = ((state_q == ST_LAST) && !write_q)
                      ? {mem[wordBase | AW'(3)], mem[wordBase | AW'(2)],
                         mem[wordBase | AW'(1)], mem[wordBase]}
                      : '0;

endmodule
